// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry helpers for the data cache
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    WRITE,
    RESP
  } dcache_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        uncached;
  } dcache_req_t;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_words);
    return 32 - offset_w(line_words) - index_w(sets);
  endfunction

endpackage

// File: rtl/dcache_bank.sv
// rtl/dcache_bank.sv - tag/data arrays with registered read, byte-enable writes, flop valid bits
module dcache_bank
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_W    = index_w(SETS),
  parameter int TAG_W      = tag_w(SETS, LINE_WORDS),
  parameter int WORD_W     = offset_w(LINE_WORDS) - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [WORD_W-1:0]  rd_word,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [3:0]         wr_be,
  input  logic [31:0]        wr_data,
  input  logic               vld_we,
  input  logic               vld_set,
  input  logic [INDEX_W-1:0] vld_idx,
  input  logic [TAG_W-1:0]   vld_tag
);

  logic [SETS-1:0]              valid;
  logic [TAG_W-1:0]             tag_mem  [SETS];
  logic [LINE_WORDS-1:0][31:0]  data_mem [SETS];

  // Valid bits live in flops so reset can clear every line in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (vld_we)
        valid[vld_idx] <= vld_set;
      if (rd_en)
        rd_valid <= valid[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (vld_we && vld_set)
      tag_mem[vld_idx] <= vld_tag;
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_be[b])
          data_mem[wr_idx][wr_word][b*8 +: 8] <= wr_data[b*8 +: 8];
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx][rd_word];
    end
  end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-through no-write-allocate data cache for the MEM stage
module dcache
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  input  logic        uncached,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic [7:0]  rd_len,
  input  logic        rd_ready,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data,
  output logic        wr_req,
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_strb,
  output logic [31:0] wr_data,
  input  logic        wr_ready
);

  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(SETS, LINE_WORDS);
  localparam int WORD_W   = OFFSET_W - 2;

  dcache_state_t      state;
  dcache_req_t        req;
  logic [WORD_W-1:0]  cnt;
  logic               full_q;
  logic [31:0]        resp_word;

  logic               bank_valid;
  logic [TAG_W-1:0]   bank_tag;
  logic [31:0]        bank_word;
  logic               bw_en, vld_we, vld_set;
  logic [WORD_W-1:0]  bw_word;
  logic [3:0]         bw_be;
  logic [31:0]        bw_data;
  logic               hit, load_hit, last_beat;

  logic [INDEX_W-1:0] req_idx;
  logic [WORD_W-1:0]  req_word;
  assign req_idx  = req.addr[OFFSET_W +: INDEX_W];
  assign req_word = req.addr[2 +: WORD_W];

  assign hit       = (state == LOOKUP) && bank_valid &&
                     (bank_tag == req.addr[31 -: TAG_W]) && !req.uncached;
  assign load_hit  = hit && !req.we;
  assign last_beat = (state == REFILL) && ret_valid && ret_last;

  assign addr_ok = (state == IDLE) && ce;
  assign data_ok = load_hit || (state == RESP);
  assign rdata   = load_hit ? bank_word : ((state == RESP) ? resp_word : 32'd0);

  always_comb begin
    bw_en   = 1'b0;
    bw_word = req_word;
    bw_be   = req.sel;
    bw_data = req.wdata;
    if (hit && req.we) begin
      bw_en = 1'b1;
    end else if ((state == REFILL) && ret_valid && !req.uncached) begin
      bw_en   = 1'b1;
      bw_word = cnt;
      bw_be   = 4'hf;
      bw_data = ret_data;
    end
  end

  // Line is invalidated as the refill starts, so a short burst leaves it invalid
  always_comb begin
    vld_we  = 1'b0;
    vld_set = 1'b0;
    if ((state == MISS_REQ) && rd_ready && !req.uncached) begin
      vld_we = 1'b1;
    end else if (last_beat && !req.uncached &&
                 (full_q || (cnt == WORD_W'(LINE_WORDS - 1)))) begin
      vld_we  = 1'b1;
      vld_set = 1'b1;
    end
  end

  dcache_bank #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .INDEX_W    (INDEX_W),
    .TAG_W      (TAG_W),
    .WORD_W     (WORD_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (addr_ok),
    .rd_idx   (addr[OFFSET_W +: INDEX_W]),
    .rd_word  (addr[2 +: WORD_W]),
    .rd_valid (bank_valid),
    .rd_tag   (bank_tag),
    .rd_data  (bank_word),
    .wr_en    (bw_en),
    .wr_idx   (req_idx),
    .wr_word  (bw_word),
    .wr_be    (bw_be),
    .wr_data  (bw_data),
    .vld_we   (vld_we),
    .vld_set  (vld_set),
    .vld_idx  (req_idx),
    .vld_tag  (req.addr[31 -: TAG_W])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req       <= '0;
      cnt       <= '0;
      full_q    <= 1'b0;
      resp_word <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      rd_len    <= '0;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_strb   <= '0;
      wr_data   <= '0;
    end else begin
      case (state)
        IDLE: if (ce) begin
          req       <= '{we: we, addr: addr, sel: sel, wdata: wdata, uncached: uncached};
          resp_word <= '0;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          if (req.we) begin
            wr_req  <= 1'b1;
            wr_addr <= req.addr;
            wr_strb <= req.sel;
            wr_data <= req.wdata;
            state   <= WRITE;
          end else if (hit) begin
            state <= IDLE;
          end else begin
            rd_req  <= 1'b1;
            rd_addr <= req.uncached ? {req.addr[31:2], 2'b00}
                                    : {req.addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
            rd_len  <= req.uncached ? 8'd0 : 8'(LINE_WORDS - 1);
            state   <= MISS_REQ;
          end
        end
        MISS_REQ: if (rd_ready) begin
          rd_req <= 1'b0;
          cnt    <= '0;
          full_q <= 1'b0;
          state  <= REFILL;
        end
        REFILL: if (ret_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == WORD_W'(LINE_WORDS - 1))
            full_q <= 1'b1;
          if (req.uncached ? (cnt == '0) : (cnt == req_word))
            resp_word <= ret_data;
          if (ret_last)
            state <= RESP;
        end
        WRITE: if (wr_ready) begin
          wr_req <= 1'b0;
          state  <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
